branch_resolve_unit: RTL and testbench
======================================

// Module: branch_resolve_unit
// PURPOSE
//  Resolves conditional branches at the MEM stage and compares the actual outcome with the fetch-time BTB prediction.
//  Drives the BTB write port: tag, target, and 2-bit history update.
//  On a mispredict, raises a one-cycle redirect of the fetch PC and flushes IF/ID, ID/EX and EX/MEM.
//  Sits downstream of branch_target_buffer and consumes the prediction carried down the pipeline latches.
//  Keeps saturating branch and mispredict performance counters.
// PARAMETERS
//  IDX_W   2   BTB index width; index = pc[IDX_W+1:2]
//  TAG_W   28  BTB tag width; tag = pc[31:IDX_W+2], so IDX_W+TAG_W == 30
//  CNT_W   16  performance counter width
// PORTS
//  CLK                 in   1      clock, rising edge
//  RST                 in   1      reset, synchronous, active-high
//  stall               in   1      pipeline held (dcache wait); no state advances
//  mem_valid           in   1      MEM latch holds a real instruction
//  mem_is_branch       in   1      instruction is BEQ/BNE
//  mem_taken           in   1      actual branch outcome
//  mem_pc              in   32     branch PC
//  mem_target          in   32     computed branch target
//  mem_hit             in   1      BTB hit recorded at fetch
//  mem_pred_target     in   30     BTB target recorded at fetch (word address)
//  mem_history         in   2      BTB history recorded at fetch
//  btb_wen             out  1      BTB write strobe (one-cycle pulse)
//  mapping_wsel        out  IDX_W  BTB write index
//  tag_bits_new        out  TAG_W  BTB write tag
//  target_address_new  out  30     BTB write target
//  branch_history_new  out  2      BTB write history
//  redirect_valid      out  1      fetch must load redirect_pc
//  redirect_pc         out  32     corrected fetch PC
//  flush_ifid, flush_idex, flush_exmem  out 1 each  pipeline flushes
//  branch_count        out  CNT_W  resolved branches
//  mispredict_count    out  CNT_W  mispredicted branches
// BEHAVIOUR
//  - Reset: every output is 0. FSM goes to IDLE. Reset mid-FLUSH abandons the redirect and the pending write.
//  - resolve = mem_valid & mem_is_branch & ~stall & (state==IDLE).
//  - pred_taken = mem_hit & mem_history[1].
//  - mispredict = (mem_taken != pred_taken) | (mem_taken & pred_taken & mem_pred_target != mem_target[31:2]).
//  - Latency: all outputs are registered and appear the cycle after resolve.
//  - BTB write (write when resolve & (mem_taken | mem_hit)):
//      wsel = mem_pc[IDX_W+1:2]; tag = mem_pc[31:IDX_W+2];
//      target = mem_taken ? mem_target[31:2] : mem_pred_target.
//  - History encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
//      On a hit, saturating +1 if taken, -1 if not; 11+taken = 11, 00+not-taken = 00.
//      On a miss with allocation (taken), history = 10.
//      A not-taken miss writes nothing.
//  - FSM IDLE -> FLUSH on resolve & mispredict:
//      redirect_pc = mem_taken ? mem_target : mem_pc+4;
//      redirect_valid and all three flushes are asserted.
//  - FLUSH -> IDLE after exactly one non-stalled cycle.
//      While stalled in FLUSH, redirect, flushes and the data outputs all hold.
//      btb_wen pulses only in the first FLUSH cycle.
//  - MEM inputs seen in FLUSH are wrong-path: no BTB write, no counter update, no resolve.
//  - btb_wen is a one-cycle pulse and drops the next cycle even under stall; write data holds until the next write.
//  - Counters:
//      branch_count +1 per resolve; mispredict_count +1 per mispredict.
//      Both saturate at all-ones with no wrap.
//      Both are updated in the same cycle as the other registered outputs.
//  - A correctly predicted branch causes no flush and no redirect; it still writes history.
// STRUCTURE
//  - In cpu_types_pkg: typedef enum {IDLE, FLUSH} bru_state_t; typedef logic [1:0] bhist_t;
//    constants WEAK_TAKEN=2'b10, STRONG_TAKEN=2'b11, STRONG_NTAKEN=2'b00.
//  - One sub-module: sat_counter2, the 2-bit saturating history update. It is combinational and reused by any future BHT.
//  - Performance counters are inline.
// TESTING
//  1. Hit, history 11, taken, pred_target matches -> no flush; btb_wen=1 with history 11; branch_count=1; mispredict_count=0.
//  2. Miss, taken, pc=0x40, target=0x80 -> flushes and redirect_valid for 1 cycle; redirect_pc=0x80; wsel=0;
//     tag=0x4; target_new=0x20; history 10.
//  3. Hit, history 10, not taken, pc=0x100 -> redirect_pc=0x104; history_new=01; mispredict_count +1.
//  4. Miss, not taken -> btb_wen=0; no flush; branch_count +1.
//  5. Mispredict, then a valid branch in MEM during FLUSH -> that branch is ignored; counters change by exactly 1 mispredict.
//  6. stall=1 for 3 cycles in FLUSH, then RST asserted mid-FLUSH -> outputs hold during the stall, then all outputs 0 and state IDLE.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared pipeline types for the branch resolution logic: FSM states and
// 2-bit branch history encoding (00 strong-NT .. 11 strong-T).
package cpu_types_pkg;

  typedef enum logic {IDLE, FLUSH} bru_state_t;

  typedef logic [1:0] bhist_t;

  localparam bhist_t STRONG_NTAKEN = 2'b00;
  localparam bhist_t WEAK_TAKEN    = 2'b10;
  localparam bhist_t STRONG_TAKEN  = 2'b11;

endpackage

// File: rtl/sat_counter2.sv
// Combinational 2-bit saturating history update: +1 on taken, -1 on not taken,
// clamped at strong-taken / strong-not-taken.
module sat_counter2
  import cpu_types_pkg::*;
(
  input  bhist_t hist_i,
  input  logic   taken_i,
  output bhist_t hist_o
);

  always_comb begin
    hist_o = hist_i;
    if (taken_i) begin
      if (hist_i != STRONG_TAKEN) hist_o = hist_i + 2'd1;
    end else begin
      if (hist_i != STRONG_NTAKEN) hist_o = hist_i - 2'd1;
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// MEM-stage branch resolution: checks the fetch-time BTB prediction, updates the
// BTB, redirects fetch and flushes the front pipeline on a mispredict.
module branch_resolve_unit
  import cpu_types_pkg::*;
#(
  parameter int unsigned IDX_W = 2,
  parameter int unsigned TAG_W = 28,
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             stall,
  input  logic             mem_valid,
  input  logic             mem_is_branch,
  input  logic             mem_taken,
  input  logic [31:0]      mem_pc,
  input  logic [31:0]      mem_target,
  input  logic             mem_hit,
  input  logic [29:0]      mem_pred_target,
  input  logic [1:0]       mem_history,
  output logic             btb_wen,
  output logic [IDX_W-1:0] mapping_wsel,
  output logic [TAG_W-1:0] tag_bits_new,
  output logic [29:0]      target_address_new,
  output logic [1:0]       branch_history_new,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             flush_exmem,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  bru_state_t       state_q;
  logic             btb_wen_q;
  logic [IDX_W-1:0] wsel_q;
  logic [TAG_W-1:0] tag_q;
  logic [29:0]      target_q;
  bhist_t           hist_q;
  logic             redirect_q;
  logic [31:0]      redirect_pc_q;
  logic             flush_q;
  logic [CNT_W-1:0] branch_cnt_q;
  logic [CNT_W-1:0] mispred_cnt_q;

  logic   resolve;
  logic   pred_taken;
  logic   mispredict;
  logic   btb_write;
  bhist_t hist_upd;

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  assign resolve    = mem_valid & mem_is_branch & ~stall & (state_q == IDLE);
  assign pred_taken = mem_hit & mem_history[1];
  assign mispredict = (mem_taken != pred_taken) |
                      (mem_taken & pred_taken & (mem_pred_target != mem_target[31:2]));
  // Not-taken misses are not allocated in the BTB.
  assign btb_write  = resolve & (mem_taken | mem_hit);

  sat_counter2 u_hist_upd (
    .hist_i  (mem_history),
    .taken_i (mem_taken),
    .hist_o  (hist_upd)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= IDLE;
      btb_wen_q     <= 1'b0;
      wsel_q        <= '0;
      tag_q         <= '0;
      target_q      <= '0;
      hist_q        <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      flush_q       <= 1'b0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      // Write strobe is a single-cycle pulse regardless of stall.
      btb_wen_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (resolve) begin
            if (branch_cnt_q != CntMax) branch_cnt_q <= branch_cnt_q + CntOne;
            if (btb_write) begin
              btb_wen_q <= 1'b1;
              wsel_q    <= mem_pc[IDX_W+1:2];
              tag_q     <= mem_pc[31:IDX_W+2];
              target_q  <= mem_taken ? mem_target[31:2] : mem_pred_target;
              hist_q    <= mem_hit ? hist_upd : WEAK_TAKEN;
            end
            if (mispredict) begin
              state_q       <= FLUSH;
              redirect_q    <= 1'b1;
              flush_q       <= 1'b1;
              redirect_pc_q <= mem_taken ? mem_target : mem_pc + 32'd4;
              if (mispred_cnt_q != CntMax) mispred_cnt_q <= mispred_cnt_q + CntOne;
            end
          end
        end
        FLUSH: begin
          // MEM contents are wrong-path here; only leave once the stall clears.
          if (!stall) begin
            state_q    <= IDLE;
            redirect_q <= 1'b0;
            flush_q    <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign btb_wen            = btb_wen_q;
  assign mapping_wsel       = wsel_q;
  assign tag_bits_new       = tag_q;
  assign target_address_new = target_q;
  assign branch_history_new = hist_q;
  assign redirect_valid     = redirect_q;
  assign redirect_pc        = redirect_pc_q;
  assign flush_ifid         = flush_q;
  assign flush_idex         = flush_q;
  assign flush_exmem        = flush_q;
  assign branch_count       = branch_cnt_q;
  assign mispredict_count   = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed and randomized checks of branch_resolve_unit against a cycle-level
// behavioural model of the resolution rules.
module tb_branch_resolve_unit;

  localparam int IDX_W = 2;
  localparam int TAG_W = 28;
  localparam int CNT_W = 16;

  logic             CLK = 1'b0;
  logic             RST;
  logic             stall;
  logic             mem_valid;
  logic             mem_is_branch;
  logic             mem_taken;
  logic [31:0]      mem_pc;
  logic [31:0]      mem_target;
  logic             mem_hit;
  logic [29:0]      mem_pred_target;
  logic [1:0]       mem_history;
  logic             btb_wen;
  logic [IDX_W-1:0] mapping_wsel;
  logic [TAG_W-1:0] tag_bits_new;
  logic [29:0]      target_address_new;
  logic [1:0]       branch_history_new;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             flush_ifid;
  logic             flush_idex;
  logic             flush_exmem;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] mispredict_count;

  always #5 CLK = ~CLK;

  branch_resolve_unit #(
    .IDX_W (IDX_W),
    .TAG_W (TAG_W),
    .CNT_W (CNT_W)
  ) dut (
    .CLK                (CLK),
    .RST                (RST),
    .stall              (stall),
    .mem_valid          (mem_valid),
    .mem_is_branch      (mem_is_branch),
    .mem_taken          (mem_taken),
    .mem_pc             (mem_pc),
    .mem_target         (mem_target),
    .mem_hit            (mem_hit),
    .mem_pred_target    (mem_pred_target),
    .mem_history        (mem_history),
    .btb_wen            (btb_wen),
    .mapping_wsel       (mapping_wsel),
    .tag_bits_new       (tag_bits_new),
    .target_address_new (target_address_new),
    .branch_history_new (branch_history_new),
    .redirect_valid     (redirect_valid),
    .redirect_pc        (redirect_pc),
    .flush_ifid         (flush_ifid),
    .flush_idex         (flush_idex),
    .flush_exmem        (flush_exmem),
    .branch_count       (branch_count),
    .mispredict_count   (mispredict_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: expected value of every output.
  bit          m_in_flush;
  logic        m_wen;
  logic [31:0] m_wsel, m_tag, m_target, m_hist, m_rpc;
  logic        m_redirect;
  int          m_bc, m_mc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sat_hist(input int h, input bit taken);
    if (taken) return (h < 3) ? h + 1 : 3;
    return (h > 0) ? h - 1 : 0;
  endfunction

  task automatic model_update();
    int  cmax;
    bit  pred, mis;
    cmax = (1 << CNT_W) - 1;
    if (RST) begin
      m_in_flush = 0; m_wen = 0; m_wsel = 0; m_tag = 0; m_target = 0; m_hist = 0;
      m_redirect = 0; m_rpc = 0; m_bc = 0; m_mc = 0;
      return;
    end
    m_wen = 0;
    if (m_in_flush) begin
      if (!stall) begin
        m_in_flush = 0;
        m_redirect = 0;
      end
    end else if (mem_valid && mem_is_branch && !stall) begin
      pred = mem_hit && mem_history[1];
      mis  = (mem_taken != pred) ||
             (mem_taken && pred && (mem_pred_target != mem_target[31:2]));
      m_bc = (m_bc < cmax) ? m_bc + 1 : cmax;
      if (mem_taken || mem_hit) begin
        m_wen    = 1;
        m_wsel   = (mem_pc / 4) % (1 << IDX_W);
        m_tag    = mem_pc >> (IDX_W + 2);
        m_target = mem_taken ? (mem_target >> 2) : 32'(mem_pred_target);
        m_hist   = mem_hit ? 32'(sat_hist(int'(mem_history), mem_taken)) : 32'd2;
      end
      if (mis) begin
        m_in_flush = 1;
        m_redirect = 1;
        m_rpc      = mem_taken ? mem_target : mem_pc + 32'd4;
        m_mc       = (m_mc < cmax) ? m_mc + 1 : cmax;
      end
    end
  endtask

  task automatic check_all(input string step);
    check({step, ".wen"},    32'(btb_wen), 32'(m_wen));
    check({step, ".wsel"},   32'(mapping_wsel), m_wsel);
    check({step, ".tag"},    32'(tag_bits_new), m_tag);
    check({step, ".target"}, 32'(target_address_new), m_target);
    check({step, ".hist"},   32'(branch_history_new), m_hist);
    check({step, ".redir"},  32'(redirect_valid), 32'(m_redirect));
    check({step, ".rpc"},    redirect_pc, m_rpc);
    check({step, ".flush"},  {29'd0, flush_ifid, flush_idex, flush_exmem},
          {29'd0, {3{m_redirect}}});
    check({step, ".bcnt"},   32'(branch_count), 32'(m_bc));
    check({step, ".mcnt"},   32'(mispredict_count), 32'(m_mc));
  endtask

  task automatic cycle(input string step);
    model_update();
    @(posedge CLK);
    #1;
    check_all(step);
  endtask

  task automatic set_br(input bit v, input bit tk, input logic [31:0] pc,
                        input logic [31:0] tgt, input bit hit,
                        input logic [29:0] ptgt, input logic [1:0] hist);
    mem_valid = v; mem_is_branch = v; mem_taken = tk; mem_pc = pc;
    mem_target = tgt; mem_hit = hit; mem_pred_target = ptgt; mem_history = hist;
  endtask

  initial begin
    RST = 1'b1; stall = 1'b0;
    set_br(0, 0, 32'h0, 32'h0, 0, 30'h0, 2'b00);
    #1;
    cycle("reset");
    cycle("reset2");
    RST = 1'b0;

    // 1: correctly predicted taken hit
    set_br(1, 1, 32'h10, 32'h200, 1, 30'h80, 2'b11);
    cycle("t1");
    check("t1.wen_c", 32'(btb_wen), 32'd1);
    check("t1.hist_c", 32'(branch_history_new), 32'h3);
    check("t1.redir_c", 32'(redirect_valid), 32'd0);
    check("t1.bc_c", 32'(branch_count), 32'd1);
    set_br(0, 0, 32'h0, 32'h0, 0, 30'h0, 2'b00);
    cycle("t1.idle");

    // 2: taken miss allocates and redirects
    set_br(1, 1, 32'h40, 32'h80, 0, 30'h0, 2'b00);
    cycle("t2");
    check("t2.rpc_c", redirect_pc, 32'h80);
    check("t2.wsel_c", 32'(mapping_wsel), 32'h0);
    check("t2.tag_c", 32'(tag_bits_new), 32'h4);
    check("t2.tgt_c", 32'(target_address_new), 32'h20);
    check("t2.hist_c", 32'(branch_history_new), 32'h2);
    check("t2.flush_c", 32'(flush_idex), 32'd1);
    set_br(0, 0, 32'h0, 32'h0, 0, 30'h0, 2'b00);
    cycle("t2.flush");
    check("t2.redir_drop", 32'(redirect_valid), 32'd0);

    // 3: predicted taken, actually not taken
    set_br(1, 0, 32'h100, 32'h300, 1, 30'hc0, 2'b10);
    cycle("t3");
    check("t3.rpc_c", redirect_pc, 32'h104);
    check("t3.hist_c", 32'(branch_history_new), 32'h1);
    check("t3.mc_c", 32'(mispredict_count), 32'd2);
    set_br(0, 0, 32'h0, 32'h0, 0, 30'h0, 2'b00);
    cycle("t3.flush");

    // 4: not-taken miss writes nothing
    set_br(1, 0, 32'h204, 32'h400, 0, 30'h0, 2'b00);
    cycle("t4");
    check("t4.wen_c", 32'(btb_wen), 32'd0);
    check("t4.bc_c", 32'(branch_count), 32'd4);

    // 5: branch in MEM during FLUSH is wrong-path
    set_br(1, 1, 32'h48, 32'h1000, 0, 30'h0, 2'b00);
    cycle("t5");
    set_br(1, 1, 32'h4c, 32'h2000, 0, 30'h0, 2'b00);
    cycle("t5.wrongpath");
    check("t5.bc_c", 32'(branch_count), 32'd5);
    check("t5.mc_c", 32'(mispredict_count), 32'd3);
    set_br(0, 0, 32'h0, 32'h0, 0, 30'h0, 2'b00);
    cycle("t5.idle");

    // 6: stall in FLUSH holds everything, then reset mid-FLUSH
    set_br(1, 1, 32'h88, 32'h500, 0, 30'h0, 2'b00);
    cycle("t6");
    stall = 1'b1;
    set_br(1, 1, 32'h8c, 32'h600, 1, 30'h10, 2'b11);
    for (int i = 0; i < 3; i++) cycle("t6.stall");
    check("t6.hold_rpc", redirect_pc, 32'h500);
    RST = 1'b1;
    cycle("t6.rst");
    check("t6.rst_redir", 32'(redirect_valid), 32'd0);
    RST = 1'b0; stall = 1'b0;
    set_br(1, 1, 32'h8c, 32'h600, 0, 30'h0, 2'b00);
    cycle("t6.idle_resolve");
    check("t6.bc_c", 32'(branch_count), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] pc, tgt;
      logic [29:0] ptgt;
      pc  = $urandom;
      tgt = $urandom;
      ptgt = ($urandom_range(3) != 0) ? tgt[31:2] : 30'($urandom);
      RST   = ($urandom_range(60) == 0);
      stall = ($urandom_range(3) == 0);
      mem_valid       = ($urandom_range(3) != 0);
      mem_is_branch   = ($urandom_range(4) != 0);
      mem_taken       = 1'($urandom);
      mem_pc          = pc;
      mem_target      = tgt;
      mem_hit         = 1'($urandom);
      mem_pred_target = ptgt;
      mem_history     = 2'($urandom);
      cycle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
